// File: rtl/alu_reservation_station_pkg.sv
// ============================================================================
// Module      : alu_reservation_station_pkg
// Description : Shared types for the ALU reservation station and its wakeup
//               helper: operation/condition/flag types, entry record, defaults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif

package alu_reservation_station_pkg;

    localparam int c_rs_entries = 4;
    localparam int c_tag_w      = 4;

    typedef enum logic [3:0] {
        ALU_PLUS, ALU_MINUS, ALU_AND, ALU_ORR, ALU_EOR, ALU_LSL, ALU_LSR, ALU_ASR,
        ALU_MOV, ALU_MOVK, ALU_CSEL, ALU_CSINV, ALU_CSINC, ALU_CSNEG, ALU_PASS_A, ALU_NOP
    } alu_op_t;

    typedef logic [3:0] cond_t;
    typedef logic [3:0] nzcv_t;

    // Tags live in separate arrays so their width can follow the TAG_W parameter.
    typedef struct packed {
        logic                 valid;
        alu_op_t              alu_op;
        logic [5:0]           alu_val_hw;
        logic                 set_cc;
        cond_t                cond;
        logic                 rdy_a;
        logic [`GPR_SIZE-1:0] val_a;
        logic                 rdy_b;
        logic [`GPR_SIZE-1:0] val_b;
        logic                 rdy_nzcv;
        nzcv_t                nzcv;
    } rs_entry_t;

    // Conditional-select family consumes the incoming flags.
    function automatic logic needs_nzcv(alu_op_t op);
        return op inside {ALU_CSEL, ALU_CSNEG, ALU_CSINC, ALU_CSINV};
    endfunction

endpackage

`default_nettype wire

// File: rtl/rs_wakeup.sv
// ============================================================================
// Module      : rs_wakeup
// Description : Single operand wakeup: captures a broadcast value when the
//               operand is still waiting on the broadcast tag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_wakeup #(
    parameter int TAG_W = 4,
    parameter int VAL_W = 64
) (
    input  logic             i_en,
    input  logic             i_rdy,
    input  logic [TAG_W-1:0] i_tag,
    input  logic [VAL_W-1:0] i_val,
    input  logic             i_cdb_valid,
    input  logic [TAG_W-1:0] i_cdb_tag,
    input  logic [VAL_W-1:0] i_cdb_val,
    output logic             o_rdy,
    output logic [VAL_W-1:0] o_val
);

    logic w_hit;

    assign w_hit = i_en && !i_rdy && i_cdb_valid && (i_tag == i_cdb_tag);
    assign o_rdy = i_rdy || w_hit;
    assign o_val = w_hit ? i_cdb_val : i_val;

endmodule

`default_nettype wire

// File: rtl/alu_reservation_station.sv
// ============================================================================
// Module      : alu_reservation_station
// Description : Collapsing age-ordered reservation station feeding one ALU,
//               with CDB wakeup, insert bypass and oldest-ready issue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int RS_ENTRIES = c_rs_entries,
    parameter int TAG_W      = c_tag_w
) (
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    input  logic                 in_flush,
    input  logic                 in_insert_valid,
    input  alu_op_t              in_alu_op,
    input  logic [5:0]           in_alu_val_hw,
    input  logic                 in_set_CC,
    input  cond_t                in_cond,
    input  logic [TAG_W-1:0]     in_dst_tag,
    input  logic [`GPR_SIZE-1:0] in_val_a,
    input  logic [`GPR_SIZE-1:0] in_val_b,
    input  logic                 in_rdy_a,
    input  logic                 in_rdy_b,
    input  logic                 in_rdy_nzcv,
    input  logic [TAG_W-1:0]     in_tag_a,
    input  logic [TAG_W-1:0]     in_tag_b,
    input  logic [TAG_W-1:0]     in_tag_nzcv,
    input  nzcv_t                in_nzcv,
    input  logic                 in_cdb_valid,
    input  logic [TAG_W-1:0]     in_cdb_tag,
    input  logic [`GPR_SIZE-1:0] in_cdb_val,
    input  logic                 in_cdb_nzcv_valid,
    input  nzcv_t                in_cdb_nzcv,
    input  logic                 in_fu_ready,
    output logic                 out_rs_full,
    output logic                 out_issue_valid,
    output alu_op_t              out_alu_op,
    output logic [`GPR_SIZE-1:0] out_val_a,
    output logic [`GPR_SIZE-1:0] out_val_b,
    output logic [5:0]           out_alu_val_hw,
    output logic                 out_set_CC,
    output cond_t                out_cond,
    output nzcv_t                out_prev_nzcv,
    output logic [TAG_W-1:0]     out_dst_tag
);

    localparam int c_cnt_w = $clog2(RS_ENTRIES + 1);
    localparam int c_idx_w = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;

    rs_entry_t          r_entry    [RS_ENTRIES];
    logic [TAG_W-1:0]   r_tag_a    [RS_ENTRIES];
    logic [TAG_W-1:0]   r_tag_b    [RS_ENTRIES];
    logic [TAG_W-1:0]   r_tag_nzcv [RS_ENTRIES];
    logic [TAG_W-1:0]   r_dst_tag  [RS_ENTRIES];
    logic [c_cnt_w-1:0] r_count;

    logic                 w_wk_rdy_a  [RS_ENTRIES];
    logic                 w_wk_rdy_b  [RS_ENTRIES];
    logic                 w_wk_rdy_n  [RS_ENTRIES];
    logic [`GPR_SIZE-1:0] w_wk_val_a  [RS_ENTRIES];
    logic [`GPR_SIZE-1:0] w_wk_val_b  [RS_ENTRIES];
    nzcv_t                w_wk_nzcv   [RS_ENTRIES];
    rs_entry_t            w_wake      [RS_ENTRIES];
    rs_entry_t            w_next      [RS_ENTRIES];
    logic [TAG_W-1:0]     w_tag_a_nxt [RS_ENTRIES];
    logic [TAG_W-1:0]     w_tag_b_nxt [RS_ENTRIES];
    logic [TAG_W-1:0]     w_tag_n_nxt [RS_ENTRIES];
    logic [TAG_W-1:0]     w_dst_nxt   [RS_ENTRIES];

    logic [RS_ENTRIES-1:0] w_ready;
    logic [c_idx_w-1:0]    w_sel;
    logic                  w_fire;
    logic                  w_full;
    logic                  w_ins_ok;
    logic [c_cnt_w-1:0]    w_base;
    rs_entry_t             w_new;
    logic                  w_new_rdy_a, w_new_rdy_b, w_new_rdy_n;
    logic [`GPR_SIZE-1:0]  w_new_val_a, w_new_val_b;
    nzcv_t                 w_new_nzcv;

    for (genvar gi = 0; gi < RS_ENTRIES; gi++) begin : g_entry
        rs_wakeup #(.TAG_W(TAG_W), .VAL_W(`GPR_SIZE)) u_wake_a (
            .i_en(r_entry[gi].valid), .i_rdy(r_entry[gi].rdy_a), .i_tag(r_tag_a[gi]),
            .i_val(r_entry[gi].val_a), .i_cdb_valid(in_cdb_valid), .i_cdb_tag(in_cdb_tag),
            .i_cdb_val(in_cdb_val), .o_rdy(w_wk_rdy_a[gi]), .o_val(w_wk_val_a[gi]));
        rs_wakeup #(.TAG_W(TAG_W), .VAL_W(`GPR_SIZE)) u_wake_b (
            .i_en(r_entry[gi].valid), .i_rdy(r_entry[gi].rdy_b), .i_tag(r_tag_b[gi]),
            .i_val(r_entry[gi].val_b), .i_cdb_valid(in_cdb_valid), .i_cdb_tag(in_cdb_tag),
            .i_cdb_val(in_cdb_val), .o_rdy(w_wk_rdy_b[gi]), .o_val(w_wk_val_b[gi]));
        rs_wakeup #(.TAG_W(TAG_W), .VAL_W(4)) u_wake_n (
            .i_en(r_entry[gi].valid), .i_rdy(r_entry[gi].rdy_nzcv), .i_tag(r_tag_nzcv[gi]),
            .i_val(r_entry[gi].nzcv), .i_cdb_valid(in_cdb_nzcv_valid), .i_cdb_tag(in_cdb_tag),
            .i_cdb_val(in_cdb_nzcv), .o_rdy(w_wk_rdy_n[gi]), .o_val(w_wk_nzcv[gi]));

        // Readiness comes from registered state; a wakeup shows up the cycle after.
        assign w_ready[gi] = r_entry[gi].valid && r_entry[gi].rdy_a && r_entry[gi].rdy_b &&
                             (r_entry[gi].rdy_nzcv || !needs_nzcv(r_entry[gi].alu_op));
    end

    // Bypass lets an operation catch a broadcast that coincides with its insert.
    rs_wakeup #(.TAG_W(TAG_W), .VAL_W(`GPR_SIZE)) u_ins_a (
        .i_en(1'b1), .i_rdy(in_rdy_a), .i_tag(in_tag_a), .i_val(in_val_a),
        .i_cdb_valid(in_cdb_valid), .i_cdb_tag(in_cdb_tag), .i_cdb_val(in_cdb_val),
        .o_rdy(w_new_rdy_a), .o_val(w_new_val_a));
    rs_wakeup #(.TAG_W(TAG_W), .VAL_W(`GPR_SIZE)) u_ins_b (
        .i_en(1'b1), .i_rdy(in_rdy_b), .i_tag(in_tag_b), .i_val(in_val_b),
        .i_cdb_valid(in_cdb_valid), .i_cdb_tag(in_cdb_tag), .i_cdb_val(in_cdb_val),
        .o_rdy(w_new_rdy_b), .o_val(w_new_val_b));
    rs_wakeup #(.TAG_W(TAG_W), .VAL_W(4)) u_ins_n (
        .i_en(1'b1), .i_rdy(in_rdy_nzcv), .i_tag(in_tag_nzcv), .i_val(in_nzcv),
        .i_cdb_valid(in_cdb_nzcv_valid), .i_cdb_tag(in_cdb_tag), .i_cdb_val(in_cdb_nzcv),
        .o_rdy(w_new_rdy_n), .o_val(w_new_nzcv));

    always_comb begin
        w_sel = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (w_ready[i]) w_sel = c_idx_w'(i);
        end
    end

    assign w_full   = (r_count == c_cnt_w'(RS_ENTRIES));
    assign w_fire   = (|w_ready) && in_fu_ready;
    assign w_ins_ok = in_insert_valid && !w_full;
    assign w_base   = r_count - c_cnt_w'(w_fire);

    always_comb begin
        w_new.valid      = 1'b1;
        w_new.alu_op     = in_alu_op;
        w_new.alu_val_hw = in_alu_val_hw;
        w_new.set_cc     = in_set_CC;
        w_new.cond       = in_cond;
        w_new.rdy_a      = w_new_rdy_a;
        w_new.val_a      = w_new_val_a;
        w_new.rdy_b      = w_new_rdy_b;
        w_new.val_b      = w_new_val_b;
        w_new.rdy_nzcv   = w_new_rdy_n;
        w_new.nzcv       = w_new_nzcv;
    end

    always_comb begin
        for (int i = 0; i < RS_ENTRIES; i++) begin
            w_wake[i]          = r_entry[i];
            w_wake[i].rdy_a    = w_wk_rdy_a[i];
            w_wake[i].val_a    = w_wk_val_a[i];
            w_wake[i].rdy_b    = w_wk_rdy_b[i];
            w_wake[i].val_b    = w_wk_val_b[i];
            w_wake[i].rdy_nzcv = w_wk_rdy_n[i];
            w_wake[i].nzcv     = w_wk_nzcv[i];
        end
        for (int i = 0; i < RS_ENTRIES; i++) begin
            int src;
            src = i;
            if (w_fire && i >= int'(w_sel)) src = (i < RS_ENTRIES - 1) ? i + 1 : i;
            w_next[i]      = w_wake[src];
            w_tag_a_nxt[i] = r_tag_a[src];
            w_tag_b_nxt[i] = r_tag_b[src];
            w_tag_n_nxt[i] = r_tag_nzcv[src];
            w_dst_nxt[i]   = r_dst_tag[src];
            // Top slot empties when the queue collapses from full.
            if (w_fire && i >= int'(w_sel) && i == RS_ENTRIES - 1) w_next[i].valid = 1'b0;
            if (w_ins_ok && c_cnt_w'(i) == w_base) begin
                w_next[i]      = w_new;
                w_tag_a_nxt[i] = in_tag_a;
                w_tag_b_nxt[i] = in_tag_b;
                w_tag_n_nxt[i] = in_tag_nzcv;
                w_dst_nxt[i]   = in_dst_tag;
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_count <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_entry[i].valid    <= 1'b0;
                r_entry[i].rdy_a    <= 1'b0;
                r_entry[i].rdy_b    <= 1'b0;
                r_entry[i].rdy_nzcv <= 1'b0;
            end
        end else if (in_flush) begin
            r_count <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) r_entry[i].valid <= 1'b0;
        end else begin
            r_count <= w_base + c_cnt_w'(w_ins_ok);
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_entry[i]    <= w_next[i];
                r_tag_a[i]    <= w_tag_a_nxt[i];
                r_tag_b[i]    <= w_tag_b_nxt[i];
                r_tag_nzcv[i] <= w_tag_n_nxt[i];
                r_dst_tag[i]  <= w_dst_nxt[i];
            end
        end
    end

    assign out_rs_full     = w_full;
    assign out_issue_valid = |w_ready;
    assign out_alu_op      = r_entry[w_sel].alu_op;
    assign out_val_a       = r_entry[w_sel].val_a;
    assign out_val_b       = r_entry[w_sel].val_b;
    assign out_alu_val_hw  = r_entry[w_sel].alu_val_hw;
    assign out_set_CC      = r_entry[w_sel].set_cc;
    assign out_cond        = r_entry[w_sel].cond;
    assign out_prev_nzcv   = r_entry[w_sel].nzcv;
    assign out_dst_tag     = r_dst_tag[w_sel];

endmodule

`default_nettype wire

// File: tb/tb_alu_reservation_station.sv
// ============================================================================
// Module      : tb_alu_reservation_station
// Description : Directed and randomized checks of alu_reservation_station
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    localparam int N  = 4;
    localparam int TW = 4;
    localparam int GW = `GPR_SIZE;

    typedef struct {
        alu_op_t        op;
        logic [5:0]     hw;
        logic           cc;
        cond_t          cond;
        logic [TW-1:0]  dst;
        logic [GW-1:0]  va, vb;
        nzcv_t          nz;
        logic           ra, rb, rn;
        logic [TW-1:0]  ta, tb, tn;
    } m_op_t;

    logic          in_clk = 1'b0;
    logic          in_rst_n = 1'b0;
    logic          in_flush = 1'b0;
    logic          in_insert_valid = 1'b0;
    logic          in_cdb_valid = 1'b0;
    logic [TW-1:0] in_cdb_tag = '0;
    logic [GW-1:0] in_cdb_val = '0;
    logic          in_cdb_nzcv_valid = 1'b0;
    nzcv_t         in_cdb_nzcv = '0;
    logic          in_fu_ready = 1'b0;
    m_op_t         ins;

    logic          out_rs_full, out_issue_valid, out_set_CC;
    alu_op_t       out_alu_op;
    logic [GW-1:0] out_val_a, out_val_b;
    logic [5:0]    out_alu_val_hw;
    cond_t         out_cond;
    nzcv_t         out_prev_nzcv;
    logic [TW-1:0] out_dst_tag;

    m_op_t mq[$];
    m_op_t mq_n[$];
    int vectors = 0;
    int miscompares = 0;

    alu_reservation_station #(.RS_ENTRIES(N), .TAG_W(TW)) dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_flush(in_flush),
        .in_insert_valid(in_insert_valid), .in_alu_op(ins.op), .in_alu_val_hw(ins.hw),
        .in_set_CC(ins.cc), .in_cond(ins.cond), .in_dst_tag(ins.dst),
        .in_val_a(ins.va), .in_val_b(ins.vb), .in_rdy_a(ins.ra), .in_rdy_b(ins.rb),
        .in_rdy_nzcv(ins.rn), .in_tag_a(ins.ta), .in_tag_b(ins.tb), .in_tag_nzcv(ins.tn),
        .in_nzcv(ins.nz), .in_cdb_valid(in_cdb_valid), .in_cdb_tag(in_cdb_tag),
        .in_cdb_val(in_cdb_val), .in_cdb_nzcv_valid(in_cdb_nzcv_valid),
        .in_cdb_nzcv(in_cdb_nzcv), .in_fu_ready(in_fu_ready),
        .out_rs_full(out_rs_full), .out_issue_valid(out_issue_valid),
        .out_alu_op(out_alu_op), .out_val_a(out_val_a), .out_val_b(out_val_b),
        .out_alu_val_hw(out_alu_val_hw), .out_set_CC(out_set_CC), .out_cond(out_cond),
        .out_prev_nzcv(out_prev_nzcv), .out_dst_tag(out_dst_tag)
    );

    always #5 in_clk = ~in_clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic bit m_ready(m_op_t e);
        bit cond_op;
        cond_op = (e.op == ALU_CSEL) || (e.op == ALU_CSINV) ||
                  (e.op == ALU_CSINC) || (e.op == ALU_CSNEG);
        return e.ra && e.rb && (e.rn || !cond_op);
    endfunction

    function automatic int m_head();
        for (int i = 0; i < mq.size(); i++) if (m_ready(mq[i])) return i;
        return -1;
    endfunction

    function automatic m_op_t m_wake(m_op_t e);
        if (in_cdb_valid && !e.ra && e.ta == in_cdb_tag) begin e.ra = 1'b1; e.va = in_cdb_val; end
        if (in_cdb_valid && !e.rb && e.tb == in_cdb_tag) begin e.rb = 1'b1; e.vb = in_cdb_val; end
        if (in_cdb_nzcv_valid && !e.rn && e.tn == in_cdb_tag) begin e.rn = 1'b1; e.nz = in_cdb_nzcv; end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int h;
        h = m_head();
        chk("rs_full", 64'(out_rs_full), 64'(mq.size() == N));
        chk("issue_valid", 64'(out_issue_valid), 64'(h >= 0));
        if (h >= 0) begin
            chk("alu_op", 64'(out_alu_op), 64'(mq[h].op));
            chk("val_a", 64'(out_val_a), 64'(mq[h].va));
            chk("val_b", 64'(out_val_b), 64'(mq[h].vb));
            chk("alu_val_hw", 64'(out_alu_val_hw), 64'(mq[h].hw));
            chk("set_CC", 64'(out_set_CC), 64'(mq[h].cc));
            chk("cond", 64'(out_cond), 64'(mq[h].cond));
            chk("prev_nzcv", 64'(out_prev_nzcv), 64'(mq[h].nz));
            chk("dst_tag", 64'(out_dst_tag), 64'(mq[h].dst));
        end
    endtask

    // One clock: check presented state, predict the edge, advance, clear pulses.
    task automatic step();
        int h;
        check_outputs();
        h = m_head();
        mq_n.delete();
        if (!in_flush) begin
            mq_n = mq;
            if (in_fu_ready && h >= 0) mq_n.delete(h);
            foreach (mq_n[i]) mq_n[i] = m_wake(mq_n[i]);
            if (in_insert_valid && mq.size() < N) mq_n.push_back(m_wake(ins));
        end
        @(posedge in_clk);
        #1;
        mq = mq_n;
        in_insert_valid   = 1'b0;
        in_flush          = 1'b0;
        in_cdb_valid      = 1'b0;
        in_cdb_nzcv_valid = 1'b0;
    endtask

    task automatic set_op(input alu_op_t op, input logic [GW-1:0] a, input logic [GW-1:0] b,
                          input logic ra, input logic rb, input logic rn,
                          input logic [TW-1:0] ta, input logic [TW-1:0] tb, input logic [TW-1:0] tn);
        ins = '{op: op, hw: 6'($urandom), cc: 1'($urandom), cond: 4'($urandom),
                dst: TW'($urandom), va: a, vb: b, nz: 4'($urandom),
                ra: ra, rb: rb, rn: rn, ta: ta, tb: tb, tn: tn};
        in_insert_valid = 1'b1;
    endtask

    initial begin
        set_op(ALU_PLUS, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        in_insert_valid = 1'b0;
        repeat (2) @(posedge in_clk);
        #1;
        chk("reset_issue_valid", 64'(out_issue_valid), 64'd0);
        chk("reset_full", 64'(out_rs_full), 64'd0);
        in_rst_n = 1'b1;

        // Minimum latency, straight-through issue
        in_fu_ready = 1'b1;
        set_op(ALU_PLUS, GW'(5), GW'(7), 1'b1, 1'b1, 1'b0, '0, '0, '0);
        step();
        chk("lat_issue_valid", 64'(out_issue_valid), 64'd1);
        chk("lat_val_a", 64'(out_val_a), 64'd5);
        chk("lat_val_b", 64'(out_val_b), 64'd7);
        step();
        chk("lat_empty", 64'(out_issue_valid), 64'd0);

        // Operand B wakeup from CDB
        set_op(ALU_MINUS, GW'(1), GW'(0), 1'b1, 1'b0, 1'b0, '0, TW'(3), '0);
        step();
        chk("wake_wait", 64'(out_issue_valid), 64'd0);
        in_cdb_valid = 1'b1; in_cdb_tag = TW'(3); in_cdb_val = GW'(16);
        step();
        chk("wake_val_b", 64'(out_val_b), 64'h10);
        step();

        // Fill, drop while full, drain in age order
        in_fu_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            set_op(ALU_AND, GW'(100 + k), GW'(k), 1'b1, 1'b1, 1'b0, '0, '0, '0);
            step();
        end
        chk("fill_full", 64'(out_rs_full), 64'd1);
        set_op(ALU_AND, GW'(999), GW'(9), 1'b1, 1'b1, 1'b0, '0, '0, '0);
        step();
        chk("drop_full", 64'(out_rs_full), 64'd1);
        in_fu_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            chk("drain_order", 64'(out_val_a), 64'(100 + k));
            step();
        end
        chk("drain_empty", 64'(out_issue_valid), 64'd0);

        // Younger ready entry overtakes a waiting older one
        in_fu_ready = 1'b0;
        set_op(ALU_PLUS, GW'(32'h99), GW'(1), 1'b0, 1'b1, 1'b0, TW'(2), '0, '0);
        step();
        set_op(ALU_MINUS, GW'(32'h21), GW'(2), 1'b1, 1'b1, 1'b0, '0, '0, '0);
        step();
        chk("ooo_first", 64'(out_val_a), 64'h21);
        in_fu_ready = 1'b1;
        in_cdb_valid = 1'b1; in_cdb_tag = TW'(2); in_cdb_val = GW'(32'h20);
        step();
        chk("ooo_second_valid", 64'(out_issue_valid), 64'd1);
        chk("ooo_second", 64'(out_val_a), 64'h20);
        step();

        // CSEL waits on flags
        set_op(ALU_CSEL, GW'(1), GW'(2), 1'b1, 1'b1, 1'b0, '0, '0, TW'(5));
        step();
        chk("csel_wait", 64'(out_issue_valid), 64'd0);
        in_cdb_nzcv_valid = 1'b1; in_cdb_tag = TW'(5); in_cdb_nzcv = 4'b0100;
        step();
        chk("csel_valid", 64'(out_issue_valid), 64'd1);
        chk("csel_nzcv", 64'(out_prev_nzcv), 64'b0100);
        step();

        // Flush and asynchronous reset of a full queue
        in_fu_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            set_op(ALU_ORR, GW'(k), GW'(k), 1'b1, 1'b1, 1'b0, '0, '0, '0);
            step();
        end
        in_flush = 1'b1;
        step();
        chk("flush_valid", 64'(out_issue_valid), 64'd0);
        chk("flush_full", 64'(out_rs_full), 64'd0);
        for (int k = 0; k < N; k++) begin
            set_op(ALU_EOR, GW'(k), GW'(k), 1'b1, 1'b1, 1'b0, '0, '0, '0);
            step();
        end
        in_rst_n = 1'b0;
        #1;
        mq.delete();
        chk("arst_valid", 64'(out_issue_valid), 64'd0);
        chk("arst_full", 64'(out_rs_full), 64'd0);
        @(posedge in_clk);
        #1;
        in_rst_n = 1'b1;
        in_fu_ready = 1'b1;
        step();
        step();

        // Randomized traffic
        for (int c = 0; c < 500; c++) begin
            alu_op_t op;
            op = alu_op_t'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0)
                set_op(op, GW'({$urandom, $urandom}), GW'({$urandom, $urandom}),
                       1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 2) != 0), TW'($urandom_range(0, 3)),
                       TW'($urandom_range(0, 3)), TW'($urandom_range(0, 3)));
            in_fu_ready       = ($urandom_range(0, 2) != 0);
            in_cdb_valid      = 1'($urandom_range(0, 1));
            in_cdb_tag        = TW'($urandom_range(0, 3));
            in_cdb_val        = GW'({$urandom, $urandom});
            in_cdb_nzcv_valid = 1'($urandom_range(0, 1));
            in_cdb_nzcv       = 4'($urandom);
            in_flush          = ($urandom_range(0, 60) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_reservation_station.md
ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

Interface
REQ-001 Parameter RS_ENTRIES, default 4, number of buffered ALU operations.
REQ-002 Parameter TAG_W, default 4, width of producer tags (register and NZCV).
REQ-003 in_clk  input  1  clock; all state updates on rising edge.
REQ-004 in_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_flush  input  1  synchronous clear of all entries.
REQ-006 in_insert_valid  input  1  new operation offered this cycle.
REQ-007 in_alu_op / in_alu_val_hw / in_set_CC / in_cond / in_dst_tag  input  alu_op_t / 6 / 1 / cond_t / TAG_W  operation fields, passed through unchanged.
REQ-008 in_val_a, in_val_b  input  `GPR_SIZE each  operand values, valid when the matching ready bit is 1.
REQ-009 in_rdy_a, in_rdy_b, in_rdy_nzcv  input  1 each  operand or NZCV already available.
REQ-010 in_tag_a, in_tag_b, in_tag_nzcv  input  TAG_W each  producer tags awaited when the matching ready bit is 0.
REQ-011 in_nzcv  input  nzcv_t  flags, valid when in_rdy_nzcv is 1.
REQ-012 in_cdb_valid, in_cdb_tag, in_cdb_val  input  1 / TAG_W / `GPR_SIZE  result broadcast.
REQ-013 in_cdb_nzcv_valid, in_cdb_nzcv  input  1 / nzcv_t  flag broadcast, same tag as in_cdb_tag.
REQ-014 in_fu_ready  input  1  ALU accepts the presented operation.
REQ-015 out_rs_full  output  1  no free entry.
REQ-016 out_issue_valid  output  1  ready operation presented.
REQ-017 out_alu_op, out_val_a, out_val_b, out_alu_val_hw, out_set_CC, out_cond, out_prev_nzcv, out_dst_tag  output  ALU input widths  issued operation.

Function
REQ-018 Entries form a collapsing age-ordered queue: index 0 oldest; count register 0..RS_ENTRIES.
REQ-019 out_rs_full = (count == RS_ENTRIES), from registered state only.
REQ-020 Insert accepted iff in_insert_valid and not out_rs_full; inserts while full are dropped, state unchanged.
REQ-021 Entry ready when rdy_a, rdy_b set, and rdy_nzcv set if op is CSEL/CSNEG/CSINC/CSINV; otherwise NZCV readiness ignored.
REQ-022 Issue selection combinational: lowest-index ready entry drives out_* ; out_issue_valid = any ready entry.
REQ-023 Issue handshake: entry removed on an edge where out_issue_valid and in_fu_ready are both 1; presented fields stable while in_fu_ready is 0 unless an older entry becomes ready.
REQ-024 On removal of entry k, entries k+1..count-1 shift to k..count-2, order preserved.
REQ-025 Simultaneous insert and issue: new entry written at index count-1 (post-shift); count unchanged.
REQ-026 Wakeup: for every valid entry, operand with rdy=0 and tag == in_cdb_tag while in_cdb_valid captures in_cdb_val and sets rdy; NZCV likewise with in_cdb_nzcv_valid.
REQ-027 Wakeup applies to entries at their post-shift positions in the same edge.
REQ-028 Insert bypass: inserted operand with rdy=0 whose tag matches a same-cycle CDB broadcast is stored ready with the CDB value.
REQ-029 Minimum latency: operation inserted fully ready at edge E is presented (out_issue_valid=1) in the cycle after E.
REQ-030 in_flush clears count and all valid bits at next edge, overriding insert, issue and wakeup.

Reset
REQ-031 Asynchronous on in_rst_n low: count=0, all entry valid and ready bits 0, out_issue_valid=0, out_rs_full=0.
REQ-032 Reset mid-operation discards all buffered operations; none issue after release until newly inserted.
REQ-033 Entry payload fields need not be reset; out_* payload is don't-care while out_issue_valid=0.

Structure
REQ-034 Shared package (data_structures.sv): rs_entry_t struct, TAG_W and RS_ENTRIES defaults; alu_op_t, cond_t, nzcv_t reused from it.
REQ-035 One sub-module, rs_wakeup, performing per-operand tag compare and value capture; instantiated per operand field.

Verification
REQ-036 Reset, insert PLUS a=5 b=7 both ready, in_fu_ready=1 -> next cycle out_issue_valid=1, val_a=5, val_b=7; then empty.
REQ-037 Insert op with tag_b=3 not ready, then CDB tag=3 val=0x10 -> issued next cycle with val_b=0x10.
REQ-038 Insert 4 ready ops, in_fu_ready=0 -> out_rs_full=1, fifth insert dropped; release -> issue order 0,1,2,3.
REQ-039 Entry0 waits on tag 2, entry1 ready -> entry1 issues first; entry0 issues after CDB tag=2.
REQ-040 CSEL with rdy_nzcv=0 tag 5, then CDB nzcv_valid tag=5 nzcv=0b0100 -> issues with out_prev_nzcv=0b0100.
REQ-041 Full queue plus in_flush or in_rst_n low mid-stream -> count 0, out_issue_valid=0 next cycle (immediately for reset).
